// File: rtl/sprite_arb_pkg.sv
// Shared types and constants for the sprite RAM read arbiter.
package sprite_arb_pkg;

   localparam int SPRITE_DEPTH = 400;
   localparam int PIX_W        = 3;
   localparam int MAX_REQ      = 8;
   localparam int MAX_ID_W     = 3;

   typedef enum logic {W_IDLE, W_ISSUE} wr_state_t;

   // Wide enough to name any of up to MAX_REQ requesters.
   typedef logic [MAX_ID_W-1:0] req_id_t;

endpackage

// File: rtl/sprite_read_arbiter_rr_pick.sv
// Combinational round-robin pick: first asserted request after ptr, wrapping modulo N.
module rr_pick
   import sprite_arb_pkg::*;
#(
   parameter int N = 3
) (
   input  logic [N-1:0] req,
   input  req_id_t      ptr,
   output logic [N-1:0] gnt,
   output req_id_t      idx,
   output logic         any
);

   localparam int SW = (N > 1) ? $clog2(N) : 1;

   logic [SW-1:0] cand;

   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves a value unassigned (no latch).
      gnt  = '0;
      idx  = '0;
      any  = 1'b0;
      cand = '0;
      for (int i = 1; i <= N; i++) begin
         cand = SW'((int'(ptr) + i) % N);
         if (!any && req[cand]) begin
            any       = 1'b1;
            gnt[cand] = 1'b1;
            idx       = req_id_t'(cand);
         end
      end
   end

endmodule

// File: rtl/sprite_read_arbiter.sv
// Round-robin read arbiter and write sequencer for the shared sprite frame RAM.
// Optional SPRITE_ARB_STATS_EN adds saturating grant/stall counters.
module sprite_read_arbiter
   import sprite_arb_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int DEPTH   = SPRITE_DEPTH,
   parameter int AW      = 19,
   parameter int DW      = 5
) (
   input  logic                          Clk,
   input  logic                          Reset,
   input  logic [NUM_REQ-1:0]            rd_req,
   input  logic [NUM_REQ-1:0][AW-1:0]    rd_addr,
   output logic [NUM_REQ-1:0]            rd_gnt,
   output logic                          rd_valid,
   output logic [$clog2(NUM_REQ)-1:0]    rd_id,
   output logic [DW-1:0]                 rd_data,
   output logic                          rd_err,
   input  logic                          wr_req,
   input  logic [AW-1:0]                 wr_addr,
   input  logic [DW-1:0]                 wr_data,
   output logic                          wr_ack,
   output logic                          wr_err,
   output logic [AW-1:0]                 ram_read_address,
   output logic [AW-1:0]                 ram_write_address,
   output logic [DW-1:0]                 ram_data_In,
   output logic                          ram_we,
`ifdef SPRITE_ARB_STATS_EN
   output logic [15:0]                   stat_grants,
   output logic [15:0]                   stat_stall,
`endif
   input  logic [DW-1:0]                 ram_data_Out
);

   localparam int            IW      = $clog2(NUM_REQ);
   localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

   // ---------------- read arbitration ----------------
   logic [NUM_REQ-1:0] req_eff;
   logic [NUM_REQ-1:0] gnt;
   req_id_t            ptr_q;
   req_id_t            win_idx;
   logic               win_any;
   logic [AW-1:0]      win_addr;
   logic               win_oor;
   logic [AW-1:0]      rd_addr_q;
   logic               vld_q;
   logic               err_q;
   logic [IW-1:0]      id_q;

   // No grant may be handed out in a cycle whose return would be wiped by reset.
   assign req_eff = Reset ? '0 : rd_req;

   rr_pick #(.N(NUM_REQ)) u_rr_pick (
      .req (req_eff),
      .ptr (ptr_q),
      .gnt (gnt),
      .idx (win_idx),
      .any (win_any)
   );

   assign rd_gnt           = gnt;
   assign win_addr         = rd_addr[win_idx];
   assign win_oor          = (win_addr >= DEPTH_A);
   assign ram_read_address = win_any ? (win_oor ? '0 : win_addr) : rd_addr_q;

   always_ff @(posedge Clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (Reset) begin
         ptr_q     <= req_id_t'(NUM_REQ - 1);
         rd_addr_q <= '0;
         vld_q     <= 1'b0;
         err_q     <= 1'b0;
         id_q      <= '0;
      end else begin
         vld_q <= win_any;
         err_q <= win_any & win_oor;
         if (win_any) begin
            ptr_q     <= win_idx;
            id_q      <= win_idx[IW-1:0];
            rd_addr_q <= ram_read_address;
         end
      end
   end

   // The RAM registers its output, so the granted read lands here one cycle later.
   assign rd_valid = vld_q & ~Reset;
   assign rd_err   = err_q & ~Reset;
   assign rd_id    = id_q;
   assign rd_data  = (rd_valid && !err_q) ? ram_data_Out : '0;

   // ---------------- write sequencer ----------------
   wr_state_t     w_state_q;
   wr_state_t     w_state_d;
   logic [AW-1:0] wa_q;
   logic [DW-1:0] wd_q;
   logic          wa_oor;

   assign wa_oor = (wa_q >= DEPTH_A);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         w_state_q <= W_IDLE;
         wa_q      <= '0;
         wd_q      <= '0;
      end else begin
         w_state_q <= w_state_d;
         if (w_state_q == W_IDLE && wr_req) begin
            wa_q <= wr_addr;
            wd_q <= wr_data;
         end
      end
   end

   always_comb begin
      w_state_d = w_state_q;
      wr_ack    = 1'b0;
      wr_err    = 1'b0;
      ram_we    = 1'b0;
      unique case (w_state_q)
         W_IDLE: begin
            if (wr_req) w_state_d = W_ISSUE;
         end
         W_ISSUE: begin
            w_state_d = W_IDLE;
            wr_ack    = ~Reset;
            wr_err    = ~Reset & wa_oor;
            ram_we    = ~Reset & ~wa_oor;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   assign ram_write_address = wa_q;
   assign ram_data_In       = wd_q;

`ifdef SPRITE_ARB_STATS_EN
   // ---------------- statistics ----------------
   logic any_stall;

   assign any_stall = |(req_eff & ~gnt);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         stat_grants <= '0;
         stat_stall  <= '0;
      end else begin
         if (win_any && stat_grants != 16'hFFFF) stat_grants <= stat_grants + 16'd1;
         if (any_stall && stat_stall != 16'hFFFF) stat_stall <= stat_stall + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sprite_read_arbiter.sv
// Directed bench for sprite_read_arbiter: read-before-write RAM model plus a read-return scoreboard.
module tb_sprite_read_arbiter;

   localparam int NUM_REQ = 3;
   localparam int AW      = 19;
   localparam int DW      = 5;

   typedef struct {
      logic [1:0]    id;
      logic [DW-1:0] data;
      logic          err;
   } rd_exp_t;

   logic                       Clk;
   logic                       Reset;
   logic [NUM_REQ-1:0]         rd_req;
   logic [NUM_REQ-1:0][AW-1:0] rd_addr;
   logic [NUM_REQ-1:0]         rd_gnt;
   logic                       rd_valid;
   logic [1:0]                 rd_id;
   logic [DW-1:0]              rd_data;
   logic                       rd_err;
   logic                       wr_req;
   logic [AW-1:0]              wr_addr;
   logic [DW-1:0]              wr_data;
   logic                       wr_ack;
   logic                       wr_err;
   logic [AW-1:0]              ram_read_address;
   logic [AW-1:0]              ram_write_address;
   logic [DW-1:0]              ram_data_In;
   logic                       ram_we;
   logic [DW-1:0]              ram_data_Out;
`ifdef SPRITE_ARB_STATS_EN
   logic [15:0]                stat_grants;
   logic [15:0]                stat_stall;
`endif

   int      n_checks = 0;
   int      n_pass   = 0;
   rd_exp_t exp_q[$];

   sprite_read_arbiter #(.NUM_REQ(NUM_REQ), .DEPTH(400), .AW(AW), .DW(DW)) dut (
      .Clk               (Clk),
      .Reset             (Reset),
      .rd_req            (rd_req),
      .rd_addr           (rd_addr),
      .rd_gnt            (rd_gnt),
      .rd_valid          (rd_valid),
      .rd_id             (rd_id),
      .rd_data           (rd_data),
      .rd_err            (rd_err),
      .wr_req            (wr_req),
      .wr_addr           (wr_addr),
      .wr_data           (wr_data),
      .wr_ack            (wr_ack),
      .wr_err            (wr_err),
      .ram_read_address  (ram_read_address),
      .ram_write_address (ram_write_address),
      .ram_data_In       (ram_data_In),
      .ram_we            (ram_we),
`ifdef SPRITE_ARB_STATS_EN
      .stat_grants       (stat_grants),
      .stat_stall        (stat_stall),
`endif
      .ram_data_Out      (ram_data_Out)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Read-before-write frame RAM; contents are i % 8 except mem[7] = 1, loaded on the first reset.
   logic [DW-1:0] mem [0:399];
   bit            ram_loaded = 1'b0;

   always @(posedge Clk) begin
      if (Reset && !ram_loaded) begin
         for (int i = 0; i < 400; i++) mem[i] <= (i == 7) ? DW'(1) : DW'(i % 8);
         ram_loaded <= 1'b1;
      end else begin
         ram_data_Out <= mem[ram_read_address];
         if (ram_we) mem[ram_write_address] <= ram_data_In;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic push_rd(input logic [1:0] id, input logic [DW-1:0] data, input logic err);
      rd_exp_t e;
      e.id   = id;
      e.data = data;
      e.err  = err;
      exp_q.push_back(e);
   endtask

   initial begin
      logic [DW-1:0] s1_data [3];
      logic [AW-1:0] s1_addr [3];
      s1_data = '{5'd2, 5'd4, 5'd6};
      s1_addr = '{19'd10, 19'd20, 19'd30};

      Reset   = 1'b1;
      rd_req  = '0;
      rd_addr = '0;
      wr_req  = 1'b0;
      wr_addr = '0;
      wr_data = '0;

      fork
         forever begin
            @(negedge Clk);
            if (rd_valid === 1'b1) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  $display("FAIL rd_beat_unexpected: got id %0d data %0h, expected no beat (t=%0t)",
                           rd_id, rd_data, $time);
               end else begin
                  rd_exp_t e;
                  e = exp_q.pop_front();
                  check("rd_id", 32'(rd_id), 32'(e.id));
                  check("rd_data", 32'(rd_data), 32'(e.data));
                  check("rd_err", 32'(rd_err), 32'(e.err));
               end
            end
         end
      join_none

      repeat (3) tick();
      Reset = 1'b0;
      @(negedge Clk);
      check("rst_rd_valid", 32'(rd_valid), 0);
      check("rst_rd_err", 32'(rd_err), 0);
      check("rst_rd_id", 32'(rd_id), 0);
      check("rst_rd_data", 32'(rd_data), 0);
      check("rst_wr_ack", 32'(wr_ack), 0);
      check("rst_ram_we", 32'(ram_we), 0);
      check("rst_ram_raddr", 32'(ram_read_address), 0);
      check("rst_ram_waddr", 32'(ram_write_address), 0);
      check("rst_rd_gnt", 32'(rd_gnt), 0);
`ifdef SPRITE_ARB_STATS_EN
      check("rst_stat_grants", 32'(stat_grants), 0);
`endif
      tick();

      // All three request continuously: grants rotate 0,1,2,0.
      for (int i = 0; i < 3; i++) rd_addr[i] = s1_addr[i];
      rd_req = 3'b111;
      for (int k = 0; k < 4; k++) begin
         @(negedge Clk);
         check("rr_gnt", 32'(rd_gnt), 32'(1 << (k % 3)));
         check("rr_raddr", 32'(ram_read_address), 32'(s1_addr[k % 3]));
         push_rd(2'(k % 3), s1_data[k % 3], 1'b0);
         tick();
      end
      rd_req = '0;

      // Lone requester 2 wins every cycle.
      rd_req = 3'b100;
      for (int k = 0; k < 4; k++) begin
         @(negedge Clk);
         check("solo_gnt", 32'(rd_gnt), 32'b100);
         push_rd(2'd2, 5'd6, 1'b0);
         tick();
      end
      rd_req = '0;

      // Out-of-range read.
      rd_addr[1] = 19'd400;
      rd_req     = 3'b010;
      @(negedge Clk);
      check("oor_gnt", 32'(rd_gnt), 32'b010);
      check("oor_raddr", 32'(ram_read_address), 0);
      push_rd(2'd1, 5'd0, 1'b1);
      tick();
      rd_req = '0;

      // Write 3 to address 5, then read it back.
      wr_addr = 19'd5;
      wr_data = 5'd3;
      wr_req  = 1'b1;
      @(negedge Clk);
      check("wr_idle_ack", 32'(wr_ack), 0);
      check("wr_idle_we", 32'(ram_we), 0);
      tick();
      wr_req = 1'b0;
      @(negedge Clk);
      check("wr_we", 32'(ram_we), 1);
      check("wr_waddr", 32'(ram_write_address), 5);
      check("wr_wdata", 32'(ram_data_In), 3);
      check("wr_ack", 32'(wr_ack), 1);
      check("wr_err", 32'(wr_err), 0);
      tick();
      rd_addr[0] = 19'd5;
      rd_req     = 3'b001;
      @(negedge Clk);
      check("wr_rb_gnt", 32'(rd_gnt), 32'b001);
      push_rd(2'd0, 5'd3, 1'b0);
      tick();
      rd_req = '0;

      // Out-of-range write; wr_req held through the issue cycle must be ignored.
      wr_addr = 19'd450;
      wr_data = 5'd7;
      wr_req  = 1'b1;
      tick();
      @(negedge Clk);
      check("wr_oor_ack", 32'(wr_ack), 1);
      check("wr_oor_err", 32'(wr_err), 1);
      check("wr_oor_we", 32'(ram_we), 0);
      tick();
      wr_req = 1'b0;
      @(negedge Clk);
      check("wr_issue_ignored", 32'(wr_ack), 0);
      tick();

      // Read of 7 in the issue cycle of a write to 7 sees the old value.
      wr_addr = 19'd7;
      wr_data = 5'd4;
      wr_req  = 1'b1;
      tick();
      wr_req     = 1'b0;
      rd_addr[0] = 19'd7;
      rd_req     = 3'b001;
      @(negedge Clk);
      check("rbw_we", 32'(ram_we), 1);
      check("rbw_waddr", 32'(ram_write_address), 7);
      check("rbw_gnt", 32'(rd_gnt), 32'b001);
      push_rd(2'd0, 5'd1, 1'b0);
      tick();
      @(negedge Clk);
      check("rbw_gnt2", 32'(rd_gnt), 32'b001);
      push_rd(2'd0, 5'd4, 1'b0);
      tick();
      rd_req = '0;
      tick();

      // Reset with a read return pending and a write in W_ISSUE.
      rd_addr[0] = 19'd10;
      rd_req     = 3'b001;
      wr_addr    = 19'd9;
      wr_data    = 5'd6;
      wr_req     = 1'b1;
      @(negedge Clk);
      check("mid_gnt", 32'(rd_gnt), 32'b001);
      tick();
      rd_req = '0;
      wr_req = 1'b0;
      Reset  = 1'b1;
      @(negedge Clk);
      check("mid_rst_valid", 32'(rd_valid), 0);
      check("mid_rst_ack", 32'(wr_ack), 0);
      check("mid_rst_we", 32'(ram_we), 0);
      tick();
      Reset = 1'b0;
      for (int i = 0; i < 3; i++) rd_addr[i] = s1_addr[i];
      rd_req = 3'b111;
      @(negedge Clk);
      check("post_rst_valid", 32'(rd_valid), 0);
      check("post_rst_ack", 32'(wr_ack), 0);
      check("post_rst_gnt", 32'(rd_gnt), 32'b001);
`ifdef SPRITE_ARB_STATS_EN
      check("post_rst_stat_grants", 32'(stat_grants), 0);
`endif
      push_rd(2'd0, 5'd2, 1'b0);
      tick();
      rd_addr[0] = 19'd9;
      rd_req     = 3'b001;
      @(negedge Clk);
      check("dropped_wr_gnt", 32'(rd_gnt), 32'b001);
      push_rd(2'd0, 5'd1, 1'b0);
      tick();
      rd_req = '0;

      repeat (3) tick();
      check("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
